seg7_addr_display: RTL and testbench
====================================

// Module: seg7_addr_display
// PURPOSE
// - Drives the Basys-3 four-digit seven-segment display. It shows the memory address the user is working on, next to the LEDs that carry the read data.
// - Sits beside the block memory. It consumes the read and write addresses and the read/write change pulses from the two address counters.
// - Digit 3 shows a mode letter. Digits 2..0 show the selected 10-bit address in hex.
// - Normally the read address is shown. After a write, the write address is shown for a hold time, then the display reverts to the read address.
// PARAMETERS
// - REFRESH_DIV  100000     clk cycles each digit is lit (1 ms at 100 MHz); legal range >= 2
// - HOLD_CYCLES  100000000  clk cycles the write address stays displayed after a write (1 s); legal range >= 2
// PORTS
// - clk          in   1   100 MHz clock; all logic is on its rising edge
// - reset        in   1   synchronous, active-high
// - raddr        in   10  current read address
// - waddr        in   10  current write address
// - write_pulse  in   1   one-cycle pulse: write address changed / write done
// - read_pulse   in   1   one-cycle pulse: read address changed
// - SEG          out  7   segment cathodes {g,f,e,d,c,b,a}, active-low, registered
// - DP           out  1   decimal point, active-low; constant 1 (off)
// - AN           out  4   digit anodes, active-low; AN[i]=0 lights digit i; registered
// BEHAVIOUR
// - Reset values: state=SHOW_READ, digit index=0, refresh count=0, hold count=0, latched address=0, latched mode=read, AN=4'b1111, SEG=7'b1111111, DP=1.
// - Refresh counter: counts 0..REFRESH_DIV-1. At the terminal count it returns to 0 and the digit index advances 0->1->2->3->0.
// - Outputs: registered from the current digit index, so they change one cycle after the index. Exactly one AN bit is low at any time except during reset.
// - Latch: on each 3->0 index wrap, the selected address and mode are latched, so a frame never mixes two addresses. Display latency is at most one frame (4*REFRESH_DIV) plus 1 cycle.
// - Digit map:
//   - digit0 = addr[3:0]
//   - digit1 = addr[7:4]
//   - digit2 = {2'b00, addr[9:8]}
//   - digit3 = mode letter
// - Hex font (active-low {g..a}):
//   - 0=1000000  1=1111001  2=0100100  3=0110000
//   - 4=0011001  5=0010010  6=0000010  7=1111000
//   - 8=0000000  9=0010000  A=0001000  b=0000011
//   - C=1000110  d=0100001  E=0000110  F=0001110
// - Mode letters: 'r' (read) = 7'b0101111; 'L' (load/write) = 7'b1000111.
// - State machine:
//   - SHOW_READ: selects raddr and letter 'r'. write_pulse -> SHOW_WRITE, with hold count = HOLD_CYCLES-1.
//   - SHOW_WRITE: selects waddr and letter 'L'. Hold count decrements each cycle.
//     - Hold count reaches 0 -> SHOW_READ.
//     - write_pulse -> hold count reloads to HOLD_CYCLES-1 (stays in SHOW_WRITE).
//     - read_pulse without write_pulse -> SHOW_READ on the next cycle.
//   - write_pulse and read_pulse in the same cycle: write wins (enter or stay in SHOW_WRITE, reload hold count).
// - Reset mid-hold or mid-frame: the next cycle is the full reset state. The pending hold is discarded.
// - Counters never overflow: the refresh counter wraps exactly at REFRESH_DIV-1, and the hold counter saturates at 0.
// CONFIGURATION
// - SEG7_BLANK_ZERO_EN defined: leading-zero blanking.
//   - digit2 shows SEG=7'b1111111 when addr[9:8]==0.
//   - digit1 is blank when addr[9:4]==0.
//   - digit0 and digit3 are never blanked.
//   - AN still cycles normally.
// - Not defined: all three hex digits always shown, including leading zeros.
// TESTING (REFRESH_DIV=4, HOLD_CYCLES=20, macro off unless noted)
// - Reset -> AN=1111, SEG=1111111, DP=1. After release: AN walks 1110,1101,1011,0111, each for 4 cycles, repeating.
// - raddr=10'h2A7, no pulses, after one frame -> digit0 SEG=1111000 (7), digit1 0001000 (A), digit2 0100100 (2), digit3 0101111 (r).
// - waddr=10'h013, write_pulse one cycle -> next frame shows 0,1,3 with 'L' (1000111). 'r' and raddr return once the 20-cycle hold has elapsed and a frame boundary passes.
// - During SHOW_WRITE: read_pulse alone -> SHOW_READ next cycle. read_pulse+write_pulse together -> stays in SHOW_WRITE, hold restarts at 19.
// - Reset asserted at hold count 10 -> state SHOW_READ, all outputs at reset values the next cycle.
// - SEG7_BLANK_ZERO_EN, raddr=10'h005 -> digit2 and digit1 SEG=1111111, digit0 0010010, digit3 0101111.

Source files
------------

// File: rtl/seg7_addr_display.sv
// seg7_addr_display
//   Drives the Basys-3 four-digit seven-segment display with the memory address
//   currently in use. Digit 3 shows a mode letter ('r' read, 'L' load/write),
//   digits 2..0 show a 10-bit address in hex. The read address is shown by
//   default; after a write the write address is held on the display for
//   HOLD_CYCLES cycles before reverting.
//
// Parameters
//   REFRESH_DIV  clk cycles each digit is lit (>= 2)
//   HOLD_CYCLES  clk cycles the write address stays selected after a write (>= 2)
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   raddr[9:0]   current read address
//   waddr[9:0]   current write address
//   write_pulse  one-cycle pulse: write address changed / write done
//   read_pulse   one-cycle pulse: read address changed
//   SEG[6:0]     segment cathodes {g,f,e,d,c,b,a}, active-low, registered
//   DP           decimal point, active-low, always off
//   AN[3:0]      digit anodes, active-low, registered
//
// Build option
//   SEG7_BLANK_ZERO_EN  blank leading-zero digits 2 and 1 of the address.

module seg7_addr_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] raddr,
    input  logic [9:0] waddr,
    input  logic       write_pulse,
    input  logic       read_pulse,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN
);

    localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [RefW-1:0]  RefLast = RefW'(REFRESH_DIV - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

    localparam logic [6:0] SegBlank   = 7'b1111111;
    localparam logic [6:0] SegLetterR = 7'b0101111;
    localparam logic [6:0] SegLetterL = 7'b1000111;

    typedef enum logic [0:0] {
        StShowRead,
        StShowWrite
    } state_e;

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [RefW-1:0]  refresh_q;
    logic [1:0]       digit_q;
    logic [9:0]       addr_q;
    logic             mode_write_q;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic             refresh_tc;
    logic             frame_wrap;
    logic [9:0]       sel_addr;
    logic             sel_mode_write;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign refresh_tc     = (refresh_q == RefLast);
    // Latch only on the 3->0 wrap so a frame never mixes two addresses.
    assign frame_wrap     = refresh_tc && (digit_q == 2'd3);
    assign sel_mode_write = (state_q == StShowWrite);
    assign sel_addr       = sel_mode_write ? waddr : raddr;

    // Mode FSM and hold counter; a write pulse always wins over a read pulse.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StShowRead: begin
                hold_d = '0;
                if (write_pulse) begin
                    state_d = StShowWrite;
                    hold_d  = HoldMax;
                end
            end
            StShowWrite: begin
                if (write_pulse) begin
                    hold_d = HoldMax;
                end else if (read_pulse) begin
                    state_d = StShowRead;
                    hold_d  = '0;
                end else if (hold_q == '0) begin
                    state_d = StShowRead;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            default: begin
                state_d = StShowRead;
                hold_d  = '0;
            end
        endcase
    end

    // Output decode for the digit currently indexed; registered below.
    always_comb begin
        logic [3:0] nibble;
        logic       blank;
        nibble = '0;
        blank  = 1'b0;
        seg_d  = SegBlank;
        an_d   = ~(4'b0001 << digit_q);
        unique case (digit_q)
            2'd0: nibble = addr_q[3:0];
            2'd1: begin
                nibble = addr_q[7:4];
`ifdef SEG7_BLANK_ZERO_EN
                blank  = (addr_q[9:4] == 6'd0);
`endif
            end
            2'd2: begin
                nibble = {2'b00, addr_q[9:8]};
`ifdef SEG7_BLANK_ZERO_EN
                blank  = (addr_q[9:8] == 2'd0);
`endif
            end
            default: nibble = '0;
        endcase
        if (digit_q == 2'd3) begin
            seg_d = mode_write_q ? SegLetterL : SegLetterR;
        end else if (blank) begin
            seg_d = SegBlank;
        end else begin
            seg_d = hex_font(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StShowRead;
            hold_q       <= '0;
            refresh_q    <= '0;
            digit_q      <= 2'd0;
            addr_q       <= '0;
            mode_write_q <= 1'b0;
            seg_q        <= SegBlank;
            an_q         <= 4'b1111;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (refresh_tc) begin
                refresh_q <= '0;
                digit_q   <= digit_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + RefW'(1);
            end
            if (frame_wrap) begin
                addr_q       <= sel_addr;
                mode_write_q <= sel_mode_write;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;
    assign DP  = 1'b1;

endmodule

// File: tb/tb_seg7_addr_display.sv
// Scoreboard bench for seg7_addr_display (REFRESH_DIV=4, HOLD_CYCLES=20).
// Stimulus pushes the expected {AN,SEG} of every digit of each frame; the
// monitor pops one entry whenever AN moves to a new digit.

module tb_seg7_addr_display;

    localparam int unsigned RefreshDiv = 4;
    localparam int unsigned HoldCycles = 20;
    localparam int unsigned FrameLen   = 4 * RefreshDiv;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;
    localparam logic [6:0] H5 = 7'b0010010;
    localparam logic [6:0] H7 = 7'b1111000;
    localparam logic [6:0] HA = 7'b0001000;
    localparam logic [6:0] HC = 7'b1000110;
    localparam logic [6:0] HF = 7'b0001110;
    localparam logic [6:0] LR = 7'b0101111;
    localparam logic [6:0] LL = 7'b1000111;
`ifdef SEG7_BLANK_ZERO_EN
    localparam logic [6:0] Z1 = 7'b1111111;
    localparam logic [6:0] Z2 = 7'b1111111;
`else
    localparam logic [6:0] Z1 = H0;
    localparam logic [6:0] Z2 = H0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] raddr = '0;
    logic [9:0] waddr = '0;
    logic       write_pulse = 1'b0;
    logic       read_pulse = 1'b0;
    logic [6:0] SEG;
    logic       DP;
    logic [3:0] AN;

    always #5 clk = ~clk;

    seg7_addr_display #(
        .REFRESH_DIV(RefreshDiv),
        .HOLD_CYCLES(HoldCycles)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .waddr      (waddr),
        .write_pulse(write_pulse),
        .read_pulse (read_pulse),
        .SEG        (SEG),
        .DP         (DP),
        .AN         (AN)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Monitor: a change of AN is a new digit being presented.
    logic [3:0] prev_an;
    int         dwell;
    bit         dwell_valid;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_an     = 4'b1111;
            dwell       = 0;
            dwell_valid = 1'b0;
        end else if (AN !== prev_an) begin
            if (dwell_valid) begin
                checks++;
                if (dwell != int'(RefreshDiv)) begin
                    errors++;
                    $display("FAIL dwell: an=%b lit %0d cycles, required %0d",
                             prev_an, dwell, RefreshDiv);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_digit: an=%b seg=%b, none expected", AN, SEG);
            end else begin
                mon_e = exp_q.pop_front();
                if (AN !== mon_e.an || SEG !== mon_e.seg || DP !== 1'b1) begin
                    errors++;
                    $display("FAIL digit: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=1",
                             AN, SEG, DP, mon_e.an, mon_e.seg);
                end
            end
            prev_an     = AN;
            dwell       = 1;
            dwell_valid = 1'b1;
        end else begin
            dwell++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step(input logic wp, input logic rp);
        write_pulse = wp;
        read_pulse  = rp;
        @(posedge clk);
        #1;
        write_pulse = 1'b0;
        read_pulse  = 1'b0;
    endtask

    task automatic push_digit(input logic [3:0] an, input logic [6:0] seg);
        exp_t x;
        x.an  = an;
        x.seg = seg;
        exp_q.push_back(x);
    endtask

    // One display frame; bit k-1 of a mask pulses on the frame's k-th cycle.
    task automatic run_frame(input logic [FrameLen-1:0] wp_mask,
                             input logic [FrameLen-1:0] rp_mask,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        push_digit(4'b1110, s0);
        push_digit(4'b1101, s1);
        push_digit(4'b1011, s2);
        push_digit(4'b0111, s3);
        for (int k = 0; k < int'(FrameLen); k++) begin
            step(wp_mask[k], rp_mask[k]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (AN !== 4'b1111 || SEG !== 7'b1111111 || DP !== 1'b1) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1",
                     name, AN, SEG, DP);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected digits never shown, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_initial");

        reset  = 1'b0;
        mon_en = 1'b1;
        raddr  = 10'h2A7;
        // Frame 0 shows the reset latch: 'r' 000.
        run_frame('0, '0, H0, Z1, Z2, LR);
        // Frame 1: read address 2A7; write of 013 on cycle 10.
        waddr = 10'h013;
        run_frame(16'h0200, '0, H7, HA, H2, LR);
        // Frame 2: write address held; hold expires mid-frame.
        run_frame('0, '0, H3, H1, Z2, LL);
        // Frame 3: back to read; write then read_pulse aborts the hold.
        raddr = 10'h3FF;
        waddr = 10'h1C5;
        run_frame(16'h0008, 16'h0080, H7, HA, H2, LR);
        // Frame 4: read 3FF; write on cycle 2, write+read together on cycle 14.
        run_frame(16'h2002, 16'h2000, HF, HF, H3, LR);
        // Frames 5-6: write address held by the reloaded hold count.
        run_frame('0, '0, H5, HC, H1, LL);
        run_frame('0, '0, H5, HC, H1, LL);
        // Frame 7: hold elapsed, read address again.
        run_frame('0, '0, HF, HF, H3, LR);

        // Frame 8: write, then reset when the hold count is at 10.
        push_digit(4'b1110, HF);
        push_digit(4'b1101, HF);
        push_digit(4'b1011, H3);
        step(1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0);
        mon_en = 1'b0;
        reset  = 1'b1;
        step(1'b0, 1'b0);
        check_reset_outputs("reset_mid_hold");
        check_queue_empty("frame_before_reset");
        step(1'b0, 1'b0);
        check_reset_outputs("reset_held");
        reset  = 1'b0;
        mon_en = 1'b1;
        // Pending hold is discarded: reset latch first, then read address.
        run_frame('0, '0, H0, Z1, Z2, LR);
        run_frame('0, '0, HF, HF, H3, LR);
        mon_en = 1'b0;
        check_queue_empty("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
